// File: rtl/sync_down_counter_pkg.sv
// rtl/sync_down_counter_pkg.sv - shared types and constants for the down counter
package sync_down_counter_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/load_dec_reg.sv
// rtl/load_dec_reg.sv - loadable decrementing register with is_one flag
module load_dec_reg
    import sync_down_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             dec,
    output logic [WIDTH-1:0] value,
    output logic             is_one
);

    // Decrement is blocked at zero so the register can never wrap to all-ones.
    always_ff @(posedge clock) begin
        if (clear) begin
            value <= '0;
        end else if (load) begin
            value <= data;
        end else if (dec && (value != '0)) begin
            value <= value - WIDTH'(1);
        end
    end

    assign is_one = (value == WIDTH'(1));

endmodule

// File: rtl/sync_down_counter.sv
// rtl/sync_down_counter.sv - loadable down counter / interval timer with tc pulse
module sync_down_counter
    import sync_down_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             tc
);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] reload;
    logic             tc_next;
    logic             is_one;
    logic             terminal;
    logic             reg_load;
    logic [WIDTH-1:0] reg_data;
    logic             reg_dec;

    // A terminal edge is only one that an external load does not override.
    assign terminal = (state == ST_RUN) && enable && is_one && !load;

    // Periodic reload reuses the register's load path; one-shot just decrements 1 -> 0.
    assign reg_load = load || (terminal && auto_reload);
    assign reg_data = load ? load_value : reload;
    assign reg_dec  = (state == ST_RUN) && enable && !load;

    load_dec_reg #(
        .WIDTH (WIDTH)
    ) u_count (
        .clock  (clock),
        .clear  (clear),
        .load   (reg_load),
        .data   (reg_data),
        .dec    (reg_dec),
        .value  (q),
        .is_one (is_one)
    );

    always_ff @(posedge clock) begin
        if (clear) begin
            state  <= ST_IDLE;
            reload <= '0;
            tc     <= 1'b0;
        end else begin
            state <= state_next;
            tc    <= tc_next;
            if (load) begin
                reload <= load_value;
            end
        end
    end

    always_comb begin
        state_next = state;
        tc_next    = 1'b0;
        if (load) begin
            state_next = (load_value != '0) ? ST_RUN : ST_IDLE;
        end else if (terminal) begin
            tc_next    = 1'b1;
            state_next = auto_reload ? ST_RUN : ST_DONE;
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_sync_down_counter.sv
// tb/tb_sync_down_counter.sv - self-checking bench for sync_down_counter
module tb_sync_down_counter;

    localparam int WIDTH = 4;

    logic             clock = 1'b0;
    logic             clear = 1'b0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] load_value = '0;
    logic             enable = 1'b0;
    logic             auto_reload = 1'b0;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    logic             tc;

    int checks = 0;
    int errors = 0;
    int tc_count = 0;
    int cyc = 0;
    int tc_cycle = -1;

    // reference model: mode 0 idle, 1 counting, 2 expired
    int m_q = 0;
    int m_rel = 0;
    int m_mode = 0;
    int m_tc = 0;

    always #5 clock = ~clock;

    sync_down_counter #(.WIDTH(WIDTH)) dut (
        .clock       (clock),
        .clear       (clear),
        .load        (load),
        .load_value  (load_value),
        .enable      (enable),
        .auto_reload (auto_reload),
        .q           (q),
        .busy        (busy),
        .done        (done),
        .tc          (tc)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int clr, input int ld, input int lv, input int en, input int ar, input string tag);
        clear       = clr[0];
        load        = ld[0];
        load_value  = lv[WIDTH-1:0];
        enable      = en[0];
        auto_reload = ar[0];
        if (clr != 0) begin
            m_q = 0; m_rel = 0; m_tc = 0; m_mode = 0;
        end else if (ld != 0) begin
            m_q = lv; m_rel = lv; m_tc = 0; m_mode = (lv != 0) ? 1 : 0;
        end else if (m_mode == 1 && en != 0) begin
            if (m_q > 1) begin
                m_q = m_q - 1; m_tc = 0;
            end else begin
                m_tc = 1;
                if (ar != 0) m_q = m_rel;
                else begin m_q = 0; m_mode = 2; end
            end
        end else begin
            m_tc = 0;
        end
        @(posedge clock);
        #1;
        cyc++;
        if (tc === 1'b1) begin
            tc_count++;
            if (tc_cycle < 0) tc_cycle = cyc;
        end
        chk({tag, ".q"}, int'(q), m_q);
        chk({tag, ".tc"}, int'(tc), m_tc);
        chk({tag, ".busy"}, int'(busy), (m_mode == 1) ? 1 : 0);
        chk({tag, ".done"}, int'(done), (m_mode == 2) ? 1 : 0);
    endtask

    task automatic mark();
        tc_count = 0;
        cyc = 0;
        tc_cycle = -1;
    endtask

    initial begin
        // reset dominates a simultaneous load
        step(1, 1, 5, 1, 0, "reset0");
        step(1, 1, 5, 1, 0, "reset1");
        step(0, 0, 0, 1, 0, "reset_rel");

        // one-shot from 5, then held at 0
        step(0, 1, 5, 1, 0, "os_load");
        mark();
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, "os_cnt");
        chk("os_tc_at_5", tc_cycle, 5);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 0, "os_hold");
        chk("os_one_tc", tc_count, 1);

        // periodic 3 for 12 cycles
        step(0, 1, 3, 1, 1, "per_load");
        mark();
        for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 1, "per3");
        chk("per3_tc_count", tc_count, 4);
        chk("per3_first_tc", tc_cycle, 3);
        step(0, 1, 1, 1, 1, "per1_load");
        mark();
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1, "per1");
        chk("per1_tc_count", tc_count, 6);

        // enable gating stretches the period by 2
        step(0, 1, 3, 1, 0, "gate_load");
        mark();
        step(0, 0, 0, 1, 0, "gate_dec");
        step(0, 0, 0, 0, 0, "gate_hold0");
        step(0, 0, 0, 0, 0, "gate_hold1");
        step(0, 0, 0, 1, 0, "gate_dec1");
        step(0, 0, 0, 1, 0, "gate_term");
        chk("gate_tc_at_5", tc_cycle, 5);

        // load wins on the terminal edge
        step(0, 1, 2, 1, 1, "lt_load");
        step(0, 0, 0, 1, 1, "lt_dec");
        mark();
        step(0, 1, 7, 1, 1, "lt_reload7");
        chk("lt_no_tc", tc_count, 0);

        // load 0 goes idle
        step(0, 1, 0, 1, 1, "load0");
        step(0, 0, 0, 1, 1, "load0_idle");

        // maximum count, one-shot
        step(0, 1, 15, 1, 0, "max_load");
        mark();
        for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 0, "max_cnt");
        chk("max_tc_at_15", tc_cycle, 15);
        chk("max_one_tc", tc_count, 1);

        // clear on the terminal edge suppresses tc
        step(0, 1, 1, 1, 0, "ct_load");
        mark();
        step(1, 0, 0, 1, 0, "ct_clear");
        step(0, 0, 0, 1, 0, "ct_after");
        chk("ct_no_tc", tc_count, 0);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 2) ? 1 : 0,
                 ($urandom_range(0, 99) < 8) ? 1 : 0,
                 int'($urandom_range(0, 15)),
                 ($urandom_range(0, 99) < 80) ? 1 : 0,
                 int'($urandom_range(0, 1)),
                 "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
